config_source_arbiter: RTL and testbench

Parametrised N-channel arbiter that merges independent 32-bit configuration-word sources into one handshaked configuration write stream. Sources include the UART, bitbang, self-write and JTAG ports, and more can be added. Each channel has its own FIFO. Grants are round-robin between bitstreams. A channel that issues the sync word owns the stream until it issues the desync word or goes idle past a timeout. The block sits between the configuration source front-ends and the frame-address/frame-data logic. It replaces the fixed four-input priority selection with buffered, lockable, scalable arbitration.

---
 rtl/config_source_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_config_source_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_source_arbiter.sv
// Merges N buffered 32-bit configuration-word sources into one handshaked stream.
// Round-robin between channels; a SYNC_WORD locks the stream to one channel until DESYNC_WORD or idle timeout.
module config_source_arbiter #(
    parameter int                    NUM_CH       = 4,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    FIFO_DEPTH   = 4,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = 32'hFAB0_FAB1,
    parameter logic [DATA_WIDTH-1:0] DESYNC_WORD  = 32'hFAB0_FAB0,
    parameter int                    LOCK_TIMEOUT = 1024
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]            in_strobe,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(NUM_CH)-1:0]    out_ch,
    output logic                         lock_valid,
    output logic [$clog2(NUM_CH)-1:0]    lock_ch,
    output logic [NUM_CH-1:0]            overflow,
    input  logic                         overflow_clr
);

    localparam int CW = $clog2(NUM_CH);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem  [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]         r_wptr [NUM_CH];
    logic [PW-1:0]         r_rptr [NUM_CH];
    logic [0:0]            r_state;
    logic [CW-1:0]         r_lockCh;
    logic [CW-1:0]         r_rrPtr;
    logic [TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0] r_outData;
    logic                  r_outValid;
    logic [CW-1:0]         r_outCh;
    logic [NUM_CH-1:0]     r_overflow;

    logic [NUM_CH-1:0]     w_empty;
    logic [NUM_CH-1:0]     w_full;
    logic [NUM_CH-1:0]     w_push;
    logic                  w_grantValid;
    logic [CW-1:0]         w_grantCh;
    logic                  w_outFree;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_popData;
    logic [TW-1:0]         w_timerNext;
    logic                  w_timeout;

    function automatic logic [CW-1:0] nextCh(input logic [CW-1:0] c);
        if (int'(c) == NUM_CH - 1) return '0;
        return c + CW'(1);
    endfunction

    // Full/empty come from the wrap bit of the extra pointer MSB.
    always_comb begin
        w_empty = '0;
        w_full  = '0;
        w_push  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_empty[i] = (r_wptr[i] == r_rptr[i]);
            w_full[i]  = (r_wptr[i][AW] != r_rptr[i][AW]) &&
                         (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
            w_push[i]  = in_strobe[i] && !w_full[i];
        end
    end

    always_comb begin
        int v;
        v            = 0;
        w_grantValid = 1'b0;
        w_grantCh    = '0;
        if (r_state == ST_LOCKED) begin
            if (!w_empty[r_lockCh]) begin
                w_grantValid = 1'b1;
                w_grantCh    = r_lockCh;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                v = int'(r_rrPtr) + k;
                if (v >= NUM_CH) v = v - NUM_CH;
                if (!w_grantValid && !w_empty[v]) begin
                    w_grantValid = 1'b1;
                    w_grantCh    = CW'(v);
                end
            end
        end
    end

    assign w_outFree = !r_outValid || out_ready;
    assign w_pop     = w_outFree && w_grantValid;
    assign w_popData = r_mem[w_grantCh][r_rptr[w_grantCh][AW-1:0]];

    // Idle timer only advances while the owner has nothing buffered or arriving.
    always_comb begin
        w_timerNext = r_timer;
        if (in_strobe[r_lockCh] || w_pop) begin
            w_timerNext = '0;
        end else if (w_empty[r_lockCh] && (r_timer != {TW{1'b1}})) begin
            w_timerNext = r_timer + TW'(1);
        end
        w_timeout = (LOCK_TIMEOUT != 0) && (w_timerNext == TW'(LOCK_TIMEOUT));
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i][AW-1:0]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
            end
            r_overflow <= '0;
            r_outData  <= '0;
            r_outValid <= 1'b0;
            r_outCh    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + PW'(1);
                if (w_pop && (int'(w_grantCh) == i)) r_rptr[i] <= r_rptr[i] + PW'(1);
                if (in_strobe[i] && w_full[i]) begin
                    r_overflow[i] <= 1'b1;
                end else if (overflow_clr) begin
                    r_overflow[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_outData  <= w_popData;
                r_outCh    <= w_grantCh;
                r_outValid <= 1'b1;
            end else if (w_outFree) begin
                r_outValid <= 1'b0;
            end
        end
    end

    // Lock state changes on the same edge that loads the SYNC/DESYNC word.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= ST_UNLOCKED;
            r_lockCh <= '0;
            r_rrPtr  <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                ST_UNLOCKED: begin
                    r_timer <= '0;
                    if (w_pop) begin
                        r_rrPtr <= nextCh(w_grantCh);
                        if (w_popData == SYNC_WORD) begin
                            r_state  <= ST_LOCKED;
                            r_lockCh <= w_grantCh;
                        end
                    end
                end
                default: begin
                    if (w_pop && (w_popData == DESYNC_WORD)) begin
                        r_state <= ST_UNLOCKED;
                        r_rrPtr <= nextCh(r_lockCh);
                        r_timer <= '0;
                    end else if (w_timeout) begin
                        r_state <= ST_UNLOCKED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= w_timerNext;
                    end
                end
            endcase
        end
    end

    assign out_data   = r_outData;
    assign out_valid  = r_outValid;
    assign out_ch     = r_outCh;
    assign lock_valid = (r_state == ST_LOCKED);
    assign lock_ch    = r_lockCh;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed-vector bench for config_source_arbiter: round-robin, lock, overflow, timeout, backpressure, reset.
// Outputs are sampled 1 time unit after each rising edge; inputs are driven at the same point.
module tb_config_source_arbiter;

    localparam logic [31:0] SYNC   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC = 32'hFAB0_FAB0;

    logic         CLK;
    logic         reset;
    logic [127:0] inData;
    logic [3:0]   inStrobe;
    logic [31:0]  outData;
    logic         outValid;
    logic         outReady;
    logic [1:0]   outCh;
    logic         lockValid;
    logic [1:0]   lockCh;
    logic [3:0]   overflowFlags;
    logic         overflowClr;

    int vecCount  = 0;
    int missCount = 0;

    config_source_arbiter #(
        .NUM_CH(4), .DATA_WIDTH(32), .FIFO_DEPTH(4),
        .SYNC_WORD(SYNC), .DESYNC_WORD(DESYNC), .LOCK_TIMEOUT(8)
    ) dut (
        .CLK(CLK), .reset(reset), .in_data(inData), .in_strobe(inStrobe),
        .out_data(outData), .out_valid(outValid), .out_ready(outReady),
        .out_ch(outCh), .lock_valid(lockValid), .lock_ch(lockCh),
        .overflow(overflowFlags), .overflow_clr(overflowClr)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] strobe, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] d3);
        inStrobe = strobe;
        inData   = {d3, d2, d1, d0};
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        overflowClr = 1'b0;
        outReady    = 1'b1;
        reset       = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vecCount++;
        if (outValid !== 1'b0 || outData !== 32'h0 || outCh !== 2'd0) begin
            $display("[TB] FAIL reset_out: got v=%b d=%h ch=%0d expected v=0 d=0 ch=0", outValid, outData, outCh);
            missCount++;
        end
        vecCount++;
        if (lockValid !== 1'b0 || lockCh !== 2'd0 || overflowFlags !== 4'b0) begin
            $display("[TB] FAIL reset_lock: got lv=%b lc=%0d ov=%b expected 0 0 0000", lockValid, lockCh, overflowFlags);
            missCount++;
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] expWord [4];
        expWord = '{32'hA, 32'hB, 32'hC, 32'hD};
        doReset();
        applyStimulus(4'b1111, 32'hA, 32'hB, 32'hC, 32'hD);
        step();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            vecCount++;
            if (outValid !== 1'b1 || outData !== expWord[k] || outCh !== 2'(k)) begin
                $display("[TB] FAIL rr_word%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                         k, outValid, outData, outCh, expWord[k], k);
                missCount++;
            end
            step();
        end
        vecCount++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL rr_drain: got v=%b expected v=0", outValid);
            missCount++;
        end
    endtask

    task automatic test_lock();
        logic [31:0] expWord [8];
        logic [1:0]  expCh   [8];
        logic        expVal  [8];
        logic        expLock [8];
        expWord = '{0, 0, SYNC, 32'h11, 32'h22, DESYNC, 32'h99, 0};
        expCh   = '{0, 0, 1, 1, 1, 1, 2, 0};
        expVal  = '{0, 0, 1, 1, 1, 1, 1, 0};
        expLock = '{0, 0, 1, 1, 1, 0, 0, 0};
        doReset();
        for (int k = 0; k < 8; k++) begin
            vecCount++;
            if (outValid !== expVal[k] || lockValid !== expLock[k] ||
                (expVal[k] && (outData !== expWord[k] || outCh !== expCh[k])) ||
                (expLock[k] && lockCh !== 2'd1)) begin
                $display("[TB] FAIL lock_cyc%0d: got v=%b d=%h ch=%0d lv=%b lc=%0d expected v=%b d=%h ch=%0d lv=%b lc=1",
                         k, outValid, outData, outCh, lockValid, lockCh, expVal[k], expWord[k], expCh[k], expLock[k]);
                missCount++;
            end
            case (k)
                0:       applyStimulus(4'b0110, 0, SYNC, 32'h99, 0);
                1:       applyStimulus(4'b0010, 0, 32'h11, 0, 0);
                2:       applyStimulus(4'b0010, 0, 32'h22, 0, 0);
                3:       applyStimulus(4'b0010, 0, DESYNC, 0, 0);
                default: applyStimulus(4'b0000, 0, 0, 0, 0);
            endcase
            step();
        end
    endtask

    task automatic test_overflow();
        doReset();
        outReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(4'b0001, 32'h100 + 32'(k), 0, 0, 0);
            step();
            if (k >= 2) begin
                vecCount++;
                if (outValid !== 1'b1 || outData !== 32'h100) begin
                    $display("[TB] FAIL ovf_hold%0d: got v=%b d=%h expected v=1 d=00000100", k, outValid, outData);
                    missCount++;
                end
            end
        end
        applyStimulus(4'b0000, 0, 0, 0, 0);
        vecCount++;
        if (overflowFlags !== 4'b0001) begin
            $display("[TB] FAIL ovf_flag: got %b expected 0001", overflowFlags);
            missCount++;
        end
        outReady = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vecCount++;
            if (outValid !== 1'b1 || outData !== 32'h100 + 32'(k) || outCh !== 2'd0) begin
                $display("[TB] FAIL ovf_drain%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=0",
                         k, outValid, outData, outCh, 32'h100 + 32'(k));
                missCount++;
            end
            step();
        end
        vecCount++;
        if (outValid !== 1'b0) begin
            $display("[TB] FAIL ovf_extra: got v=%b d=%h expected v=0", outValid, outData);
            missCount++;
        end
        overflowClr = 1'b1;
        step();
        overflowClr = 1'b0;
        vecCount++;
        if (overflowFlags !== 4'b0000) begin
            $display("[TB] FAIL ovf_clear: got %b expected 0000", overflowFlags);
            missCount++;
        end
    endtask

    task automatic test_timeout();
        doReset();
        for (int k = 0; k < 14; k++) begin
            if (k == 2) begin
                vecCount++;
                if (outValid !== 1'b1 || outData !== SYNC || outCh !== 2'd3 || lockValid !== 1'b1 || lockCh !== 2'd3) begin
                    $display("[TB] FAIL to_sync: got v=%b d=%h ch=%0d lv=%b lc=%0d expected v=1 d=%h ch=3 lv=1 lc=3",
                             outValid, outData, outCh, lockValid, lockCh, SYNC);
                    missCount++;
                end
            end
            if (k >= 3 && k <= 10) begin
                vecCount++;
                if (outValid !== 1'b0) begin
                    $display("[TB] FAIL to_blocked%0d: got v=%b d=%h expected v=0", k, outValid, outData);
                    missCount++;
                end
            end
            if (k == 9 || k == 10) begin
                vecCount++;
                if (lockValid !== (k == 9)) begin
                    $display("[TB] FAIL to_lock%0d: got lv=%b expected lv=%b", k, lockValid, (k == 9));
                    missCount++;
                end
            end
            if (k == 11 || k == 12) begin
                vecCount++;
                if (outValid !== 1'b1 || outData !== 32'h200 + 32'(k - 11) || outCh !== 2'd0) begin
                    $display("[TB] FAIL to_release%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=0",
                             k, outValid, outData, outCh, 32'h200 + 32'(k - 11));
                    missCount++;
                end
            end
            case (k)
                0:       applyStimulus(4'b1000, 0, 0, 0, SYNC);
                1:       applyStimulus(4'b0001, 32'h200, 0, 0, 0);
                2:       applyStimulus(4'b0001, 32'h201, 0, 0, 0);
                default: applyStimulus(4'b0000, 0, 0, 0, 0);
            endcase
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] expWord [6];
        int          rxIdx;
        logic        prevHeld;
        logic [31:0] prevData;
        logic [1:0]  prevCh;
        expWord  = '{SYNC, 32'h301, 32'h302, 32'h303, 32'h304, DESYNC};
        rxIdx    = 0;
        prevHeld = 1'b0;
        prevData = '0;
        prevCh   = '0;
        doReset();
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0 && k / 2 < 6) applyStimulus(4'b0100, 0, 0, expWord[k / 2], 0);
            else applyStimulus(4'b0000, 0, 0, 0, 0);
            outReady = (k % 2 == 1);
            if (prevHeld) begin
                vecCount++;
                if (outValid !== 1'b1 || outData !== prevData || outCh !== prevCh) begin
                    $display("[TB] FAIL bp_hold%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                             k, outValid, outData, outCh, prevData, prevCh);
                    missCount++;
                end
            end
            if (outValid && outReady) begin
                vecCount++;
                if (rxIdx >= 6) begin
                    $display("[TB] FAIL bp_extra: got d=%h expected no word", outData);
                    missCount++;
                end else if (outData !== expWord[rxIdx] || outCh !== 2'd2 ||
                             (rxIdx >= 1 && rxIdx <= 4 && (lockValid !== 1'b1 || lockCh !== 2'd2))) begin
                    $display("[TB] FAIL bp_word%0d: got d=%h ch=%0d lv=%b lc=%0d expected d=%h ch=2",
                             rxIdx, outData, outCh, lockValid, lockCh, expWord[rxIdx]);
                    missCount++;
                end
                rxIdx++;
            end
            prevHeld = outValid && !outReady;
            prevData = outData;
            prevCh   = outCh;
            step();
        end
        outReady = 1'b1;
        vecCount++;
        if (rxIdx != 6 || lockValid !== 1'b0 || overflowFlags !== 4'b0) begin
            $display("[TB] FAIL bp_total: got words=%0d lv=%b ov=%b expected words=6 lv=0 ov=0000",
                     rxIdx, lockValid, overflowFlags);
            missCount++;
        end
    endtask

    task automatic test_passthrough();
        doReset();
        applyStimulus(4'b0011, DESYNC, 32'h401, 0, 0);
        step();
        applyStimulus(4'b0000, 0, 0, 0, 0);
        step();
        vecCount++;
        if (outValid !== 1'b1 || outData !== DESYNC || outCh !== 2'd0 || lockValid !== 1'b0) begin
            $display("[TB] FAIL pt_desync: got v=%b d=%h ch=%0d lv=%b expected v=1 d=%h ch=0 lv=0",
                     outValid, outData, outCh, lockValid, DESYNC);
            missCount++;
        end
        step();
        vecCount++;
        if (outValid !== 1'b1 || outData !== 32'h401 || outCh !== 2'd1) begin
            $display("[TB] FAIL pt_next: got v=%b d=%h ch=%0d expected v=1 d=00000401 ch=1",
                     outValid, outData, outCh);
            missCount++;
        end
    endtask

    task automatic test_reset_mid_lock();
        doReset();
        applyStimulus(4'b0010, 0, SYNC, 0, 0);
        step();
        applyStimulus(4'b0011, 32'h501, 32'h511, 0, 0);
        step();
        applyStimulus(4'b0011, 32'h502, 32'h512, 0, 0);
        outReady = 1'b0;
        step();
        vecCount++;
        if (lockValid !== 1'b1 || lockCh !== 2'd1 || outValid !== 1'b1) begin
            $display("[TB] FAIL rml_locked: got lv=%b lc=%0d v=%b expected lv=1 lc=1 v=1", lockValid, lockCh, outValid);
            missCount++;
        end
        applyStimulus(4'b0000, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        outReady = 1'b1;
        vecCount++;
        if (outValid !== 1'b0 || outData !== 32'h0 || outCh !== 2'd0 || lockValid !== 1'b0 ||
            lockCh !== 2'd0 || overflowFlags !== 4'b0) begin
            $display("[TB] FAIL rml_reset: got v=%b d=%h ch=%0d lv=%b lc=%0d ov=%b expected all zero",
                     outValid, outData, outCh, lockValid, lockCh, overflowFlags);
            missCount++;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            vecCount++;
            if (outValid !== 1'b0) begin
                $display("[TB] FAIL rml_empty%0d: got v=%b d=%h expected v=0", k, outValid, outData);
                missCount++;
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        outReady    = 1'b1;
        overflowClr = 1'b0;
        inStrobe    = '0;
        inData      = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_passthrough();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
